padding_row_serializer: RTL and testbench

Output-side counterpart of the input padding stage: accepts one fully packed, zero-padded RGB row (three 3344-bit buses at default size), strips the left and right padding pixels, and streams the interior pixels out one RGB triple per cycle under valid/ready flow control. It sits at the tail of the feature pipeline and feeds the frame writer, which rebuilds the 416x416 image. It also counts rows and pulses `intr` at end of frame.

---
 rtl/padding_row_serializer.sv | 133 +++++++++++++
 tb/tb_padding_row_serializer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/padding_row_serializer.sv
// Strips left/right padding from one captured, packed RGB row and streams the
// interior pixels out one triple per cycle, counting rows to flag end of frame.
//
// Handshakes: a row is taken on a rising edge where row_valid && row_ready;
// a pixel moves on a rising edge where outDataValid && out_ready. Neither
// valid may depend on its own ready, and a stalled pixel is held unchanged.
module padding_row_serializer #(
    parameter int WIDTH  = 416,
    parameter int HEIGHT = 416,
    parameter int PAD    = 1,
    parameter int DW     = 8,
    localparam int ROWW  = (WIDTH + 2 * PAD) * DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            row_valid,
    output logic            row_ready,
    input  logic [ROWW-1:0] R_row,
    input  logic [ROWW-1:0] G_row,
    input  logic [ROWW-1:0] B_row,
    output logic [DW-1:0]   R_out,
    output logic [DW-1:0]   G_out,
    output logic [DW-1:0]   B_out,
    output logic            outDataValid,
    input  logic            out_ready,
    output logic            row_done,
    output logic            intr,
    output logic            o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IW = $clog2(WIDTH + 2 * PAD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [HW-1:0]   r_row_cnt;
    logic [ROWW-1:0] r_r_row;
    logic [ROWW-1:0] r_g_row;
    logic [ROWW-1:0] r_b_row;
    logic [DW-1:0]   r_r_out;
    logic [DW-1:0]   r_g_out;
    logic [DW-1:0]   r_b_out;
    logic            r_row_done;
    logic            r_intr;

    logic            w_last;
    logic            w_frame_end;
    logic [IW-1:0]   w_next_idx;
    logic [DW-1:0]   w_next_r;
    logic [DW-1:0]   w_next_g;
    logic [DW-1:0]   w_next_b;

    assign w_last      = (r_col == CW'(WIDTH - 1));
    assign w_frame_end = (r_row_cnt == HW'(HEIGHT - 1));

    // Element index of the pixel that follows the one currently on the outputs.
    assign w_next_idx = IW'(r_col) + IW'(PAD + 1);
    assign w_next_r   = r_r_row[w_next_idx * DW +: DW];
    assign w_next_g   = r_g_row[w_next_idx * DW +: DW];
    assign w_next_b   = r_b_row[w_next_idx * DW +: DW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_row_cnt  <= '0;
            r_r_row    <= '0;
            r_g_row    <= '0;
            r_b_row    <= '0;
            r_r_out    <= '0;
            r_g_out    <= '0;
            r_b_out    <= '0;
            r_row_done <= 1'b0;
            r_intr     <= 1'b0;
        end else begin
            r_row_done <= 1'b0;
            r_intr     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (row_valid) begin
                        r_r_row <= R_row;
                        r_g_row <= G_row;
                        r_b_row <= B_row;
                        r_col   <= '0;
                        // First interior pixel comes straight off the bus so it
                        // is presented in the cycle right after the accept.
                        r_r_out <= R_row[PAD * DW +: DW];
                        r_g_out <= G_row[PAD * DW +: DW];
                        r_b_out <= B_row[PAD * DW +: DW];
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_state    <= IDLE;
                            r_col      <= '0;
                            r_row_done <= 1'b1;
                            if (w_frame_end) begin
                                r_intr    <= 1'b1;
                                r_row_cnt <= '0;
                            end else begin
                                r_row_cnt <= r_row_cnt + HW'(1);
                            end
                        end else begin
                            r_col   <= r_col + CW'(1);
                            r_r_out <= w_next_r;
                            r_g_out <= w_next_g;
                            r_b_out <= w_next_b;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign row_ready    = (r_state == IDLE);
    assign outDataValid = (r_state == SEND);
    assign R_out        = r_r_out;
    assign G_out        = r_g_out;
    assign B_out        = r_b_out;
    assign row_done     = r_row_done;
    assign intr         = r_intr;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_padding_row_serializer.sv
// Bench for padding_row_serializer at WIDTH=4, HEIGHT=2: directed corner cases,
// a table-driven backpressure run, then random traffic against a pixel-queue model.
module tb_padding_row_serializer;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int PAD    = 1;
    localparam int DW     = 8;
    localparam int ROWW   = (WIDTH + 2 * PAD) * DW;
    localparam logic [ROWW-1:0] BASE = {8'hBB, 8'h04, 8'h03, 8'h02, 8'h01, 8'hAA};

    logic            clk = 1'b0;
    logic            reset;
    logic            row_valid;
    logic            row_ready;
    logic [ROWW-1:0] R_row, G_row, B_row;
    logic [DW-1:0]   R_out, G_out, B_out;
    logic            outDataValid;
    logic            out_ready;
    logic            row_done;
    logic            intr;
    logic            dbg_state;

    padding_row_serializer #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .PAD   (PAD),
        .DW    (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .R_row       (R_row),
        .G_row       (G_row),
        .B_row       (B_row),
        .R_out       (R_out),
        .G_out       (G_out),
        .B_out       (B_out),
        .outDataValid(outDataValid),
        .out_ready   (out_ready),
        .row_done    (row_done),
        .intr        (intr),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       ordy;
        logic       ev;
        logic [7:0] er;
        logic       ed;
        logic       ei;
    } bp_vec_t;
    bp_vec_t bp_tbl[8];

    // Reference model state: pending pixels in emit order plus pulse predictions.
    logic [23:0] exp_q[$];
    int          pix_cnt;
    int          row_num;
    logic        exp_done;
    logic        exp_intr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ROWW-1:0] row_add(input logic [ROWW-1:0] r, input logic [7:0] d);
        logic [ROWW-1:0] res;
        for (int k = 0; k < WIDTH + 2 * PAD; k++) res[k*DW +: DW] = r[k*DW +: DW] + d;
        return res;
    endfunction

    function automatic logic [ROWW-1:0] rand_row();
        logic [ROWW-1:0] res;
        for (int k = 0; k < WIDTH + 2 * PAD; k++) res[k*DW +: DW] = 8'($urandom());
        return res;
    endfunction

    task automatic load_row(input logic [ROWW-1:0] r);
        R_row = r;
        G_row = row_add(r, 8'h10);
        B_row = row_add(r, 8'h20);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row_ready"}, row_ready, 1);
        chk({tag, "_valid"}, outDataValid, 0);
        chk({tag, "_row_done"}, row_done, 0);
        chk({tag, "_intr"}, intr, 0);
        chk({tag, "_rgb"}, {R_out, G_out, B_out}, 0);
    endtask

    task automatic model_step();
        logic        idle;
        logic [23:0] px;
        idle = (exp_q.size() == 0);
        chk("rnd_valid", outDataValid, !idle);
        chk("rnd_ready", row_ready, idle);
        chk("rnd_row_done", row_done, exp_done);
        chk("rnd_intr", intr, exp_intr);
        exp_done = 1'b0;
        exp_intr = 1'b0;
        if (!idle && out_ready) begin
            px = exp_q.pop_front();
            chk("rnd_pixel", {R_out, G_out, B_out}, px);
            pix_cnt++;
            if (pix_cnt == WIDTH) begin
                pix_cnt  = 0;
                exp_done = 1'b1;
                exp_intr = ((row_num % HEIGHT) == HEIGHT - 1);
                row_num++;
            end
        end
        if (idle && row_valid)
            for (int k = 0; k < WIDTH; k++)
                exp_q.push_back({R_row[(k+PAD)*DW +: DW], G_row[(k+PAD)*DW +: DW], B_row[(k+PAD)*DW +: DW]});
    endtask

    initial begin
        #300000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, done_cnt, intr_cnt, last_done, n_xfer;
        logic acc;

        reset = 1'b0; row_valid = 1'b0; out_ready = 1'b0;
        R_row = '0; G_row = '0; B_row = '0;

        // Reset and idle
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("idle");

        // Single row, no stall
        @(posedge clk); #1 row_valid = 1'b1; load_row(BASE); out_ready = 1'b1;
        @(posedge clk); #1 row_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            chk("single_valid", outDataValid, 1);
            chk("single_r", R_out, 32'(i + 1));
            chk("single_g", G_out, 32'(i + 'h11));
            chk("single_b", B_out, 32'(i + 'h21));
            chk("single_no_done", row_done, 0);
        end
        @(negedge clk);
        chk("single_end_valid", outDataValid, 0);
        chk("single_row_done", row_done, 1);
        chk("single_intr", intr, 0);

        // Backpressure: second row of the frame, so intr fires with its row_done
        bp_tbl[0] = '{1'b1, 1'b1, 8'd1, 1'b0, 1'b0};
        bp_tbl[1] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b0};
        bp_tbl[2] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b0};
        bp_tbl[3] = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b0};
        bp_tbl[4] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0};
        bp_tbl[5] = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b0};
        bp_tbl[6] = '{1'b1, 1'b1, 8'd4, 1'b0, 1'b0};
        bp_tbl[7] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1};
        n_xfer = 0;
        @(posedge clk); #1 row_valid = 1'b1; load_row(BASE);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 row_valid = 1'b0; out_ready = bp_tbl[i].ordy;
            @(negedge clk);
            chk("bp_valid", outDataValid, bp_tbl[i].ev);
            if (bp_tbl[i].ev) chk("bp_r", R_out, bp_tbl[i].er);
            chk("bp_row_done", row_done, bp_tbl[i].ed);
            chk("bp_intr", intr, bp_tbl[i].ei);
            if (outDataValid && out_ready) n_xfer++;
        end
        chk("bp_transfers", n_xfer, 4);

        // Frame end and wrap: three rows back to back, reloading on row_done
        out_ready = 1'b1;
        @(posedge clk); #1 row_valid = 1'b1; load_row(rand_row());
        sent = 1; done_cnt = 0; intr_cnt = 0; last_done = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            acc = row_valid && row_ready;
            if (intr) intr_cnt++;
            if (row_done) begin
                done_cnt++;
                chk("frame_intr", intr, (done_cnt == 2));
                if (done_cnt > 1) chk("frame_period", cyc - last_done, 5);
                last_done = cyc;
            end
            if (done_cnt == 3) break;
            @(posedge clk); #1;
            if (acc) row_valid = 1'b0;
            if (row_done && sent < 3) begin
                row_valid = 1'b1;
                load_row(rand_row());
                sent++;
            end
        end
        chk("frame_rows", done_cnt, 3);
        chk("frame_intr_count", intr_cnt, 1);

        // Input isolation: row count is now 1, so this row ends the frame
        @(posedge clk); #1 row_valid = 1'b1; load_row(row_add(BASE, 8'h05));
        @(posedge clk); #1 load_row(rand_row());
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            chk("iso_valid", outDataValid, 1);
            chk("iso_ready", row_ready, 0);
            chk("iso_rgb", {R_out, G_out, B_out}, {8'(i + 6), 8'(i + 'h16), 8'(i + 'h26)});
            @(posedge clk); #1;
            if (i < WIDTH - 1) load_row(rand_row());
            else row_valid = 1'b0;
        end
        @(negedge clk);
        chk("iso_row_done", row_done, 1);
        chk("iso_intr", intr, 1);
        @(negedge clk);
        chk("iso_no_accept", outDataValid, 0);

        // Mid-row reset while row_cnt is 1
        @(posedge clk); #1 row_valid = 1'b1; load_row(BASE);
        @(posedge clk); #1 row_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(posedge clk); #1 row_valid = 1'b1;
        @(posedge clk); #1 row_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 chk_reset_vals("midrst");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 row_valid = 1'b1; load_row(row_add(BASE, 8'h30));
        @(posedge clk); #1 row_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            chk("midrst_r", R_out, 32'(i + 'h31));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("midrst_row_done", row_done, 1);
        chk("midrst_intr", intr, 0);

        // Random traffic against the queue model; row 0 of the frame is done
        pix_cnt = 0; row_num = 1; exp_done = 1'b0; exp_intr = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk); #1;
            row_valid = ($urandom_range(0, 2) == 0);
            load_row(rand_row());
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_step();
        end
        row_valid = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1 out_ready = 1'b1;
            @(negedge clk);
            model_step();
            if (exp_q.size() == 0 && !exp_done) break;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
